// File: rtl/demux_collector.sv
// Bit-serial word collector: steers one bit per handshake into position `select`
// of an N-bit register and presents the word once every position has been written.
module demux_collector #(
  parameter int SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      select,
  input  logic                  in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(1<<SEL_W)-1:0] out,
  output logic [(1<<SEL_W)-1:0] fill_mask
);

  localparam int N = 1 << SEL_W;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t         state;
  logic [N-1:0]   sel_bit;

  assign sel_bit = N'(1) << select;

  // Handshake flags decode straight from the state register, so neither
  // output has a combinational path from any input.
  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == PRESENT);

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state     <= COLLECT;
      out       <= '0;
      fill_mask <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_valid) begin
            out[select]       <= in;
            fill_mask[select] <= 1'b1;
            if ((fill_mask | sel_bit) == '1) state <= PRESENT;
          end
        end
        PRESENT: begin
          // Inputs are ignored here; the sender holds until in_ready returns.
          if (out_ready) begin
            state     <= COLLECT;
            out       <= '0;
            fill_mask <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
